// File: rtl/seg_capture.sv
// Seven-segment scan capture: debounces a multiplexed active-low segment bus,
// decodes each stable digit into BCD and presents complete 4-digit frames
// through a valid/ready handshake.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  segments,
  input  logic [3:0]  digit_sel,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_err,
  output logic        overrun
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  typedef enum logic {StCollect, StPresent} state_e;

  state_e      state_q, state_d;
  logic [6:0]  seg_q, seg_d, hold_seg_q, hold_seg_d;
  logic [3:0]  sel_q, sel_d, hold_sel_q, hold_sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hit_q, hit_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  serr_q, serr_d;
  logic        valid_q, valid_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  derr_q, derr_d;
  logic        ovr_q, ovr_d;

  logic        sel_onehot, same;
  logic [3:0]  dec_val;
  logic        dec_ok;
  logic [3:0]  cap_mask;
  logic [3:0]  mask_keep;

  // Sample stage and run counter; hit fires once when a run first reaches the threshold.
  // hold_* keeps the previous sample so that, one cycle after the hit, it holds the
  // pattern that completed the run.
  always_comb begin
    seg_d      = segments;
    sel_d      = digit_sel;
    hold_seg_d = seg_q;
    hold_sel_d = sel_q;
    sel_onehot = (sel_q != 4'b0) && ((sel_q & (sel_q - 4'd1)) == 4'b0);
    same       = (seg_q == hold_seg_q) && (sel_q == hold_sel_q);
    cnt_d      = 8'd0;
    if (sel_onehot) begin
      if (same) begin
        cnt_d = (cnt_q == StableCnt) ? cnt_q : cnt_q + 8'd1;
      end else begin
        cnt_d = 8'd1;
      end
    end
    hit_d = (cnt_d == StableCnt) && (cnt_q != StableCnt);
  end

  // Glyph decode of the pattern that completed the run.
  always_comb begin
    dec_val = 4'hF;
    dec_ok  = 1'b1;
    case (hold_seg_q)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      default: begin
        dec_val = 4'hF;
        dec_ok  = 1'b0;
      end
    endcase
  end

  // Shadow buffer write on capture.
  always_comb begin
    cap_mask = hit_q ? hold_sel_q : 4'b0;
    shadow_d = shadow_q;
    serr_d   = serr_q;
    for (int i = 0; i < 4; i++) begin
      if (cap_mask[i]) begin
        shadow_d[4*i +: 4] = dec_val;
        serr_d[i]          = ~dec_ok;
      end
    end
  end

  // Frame FSM: handshake beats overrun; a capture on the same edge always lands in the mask.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    bcd_d     = bcd_q;
    derr_d    = derr_q;
    ovr_d     = ovr_q;
    mask_keep = mask_q;
    unique case (state_q)
      StCollect: begin
        if (mask_q == 4'hF) begin
          bcd_d     = shadow_q;
          derr_d    = serr_q;
          mask_keep = 4'b0;
          valid_d   = 1'b1;
          state_d   = StPresent;
        end
      end
      StPresent: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StCollect;
        end else if (mask_q == 4'hF) begin
          ovr_d     = 1'b1;
          mask_keep = 4'b0;
        end
      end
      default: state_d = StCollect;
    endcase
    mask_d = mask_keep | cap_mask;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StCollect;
      seg_q      <= 7'b0;
      sel_q      <= 4'b0;
      hold_seg_q <= 7'b0;
      hold_sel_q <= 4'b0;
      cnt_q      <= 8'd0;
      hit_q      <= 1'b0;
      mask_q     <= 4'b0;
      shadow_q   <= 16'h0;
      serr_q     <= 4'b0;
      valid_q    <= 1'b0;
      bcd_q      <= 16'h0;
      derr_q     <= 4'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      hold_seg_q <= hold_seg_d;
      hold_sel_q <= hold_sel_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      mask_q     <= mask_d;
      shadow_q   <= shadow_d;
      serr_q     <= serr_d;
      valid_q    <= valid_d;
      bcd_q      <= bcd_d;
      derr_q     <= derr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign bcd_out   = bcd_q;
  assign digit_err = derr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed scenarios plus a randomized run
// compared against a frame-level behavioural model.
module tb_seg_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        overrun;

  int errs = 0;
  int checks = 0;

  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .segments  (segments),
    .digit_sel (digit_sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .digit_err (digit_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Behavioural model: run length on raw input samples, captures land two edges later.
  logic        m_valid, m_ovr;
  logic [15:0] m_bcd, m_shadow;
  logic [3:0]  m_derr, m_serr, m_mask;
  logic [6:0]  m_last_seg, p0_seg, p1_seg;
  logic [3:0]  m_last_sel, p0_sel, p1_sel;
  logic        p0_v, p1_v;
  int          m_run;

  function automatic void decode(input logic [6:0] s, output logic [3:0] v, output logic e);
    v = 4'hF;
    e = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (glyph[k] == s) begin
        v = 4'(k);
        e = 1'b0;
      end
    end
  endfunction

  function automatic void model_step(input logic [6:0] s, input logic [3:0] d, input logic r,
                                     input logic rs);
    logic [3:0] v;
    logic       e;
    int         prev;
    if (rs) begin
      m_valid = 0; m_ovr = 0; m_bcd = 0; m_shadow = 0; m_derr = 0; m_serr = 0; m_mask = 0;
      m_last_seg = 0; m_last_sel = 0; m_run = 0; p0_v = 0; p1_v = 0;
      p0_seg = 0; p0_sel = 0; p1_seg = 0; p1_sel = 0;
      return;
    end
    if (!m_valid) begin
      if (m_mask == 4'hF) begin
        m_bcd = m_shadow; m_derr = m_serr; m_valid = 1; m_mask = 0;
      end
    end else if (r) begin
      m_valid = 0;
    end else if (m_mask == 4'hF) begin
      m_ovr = 1; m_mask = 0;
    end
    if (p1_v) begin
      decode(p1_seg, v, e);
      for (int i = 0; i < 4; i++) begin
        if (p1_sel[i]) begin
          m_shadow[4*i +: 4] = v;
          m_serr[i] = e;
          m_mask[i] = 1'b1;
        end
      end
    end
    p1_v = p0_v; p1_seg = p0_seg; p1_sel = p0_sel;
    prev = m_run;
    if ($countones(d) != 1) m_run = 0;
    else if (s == m_last_seg && d == m_last_sel) m_run = (m_run < S) ? m_run + 1 : m_run;
    else m_run = 1;
    p0_v = (m_run == S) && (prev != S);
    p0_seg = s; p0_sel = d;
    m_last_seg = s; m_last_sel = d;
  endfunction

  task automatic tick(input logic [6:0] s, input logic [3:0] d, input logic r, input logic rs);
    segments = s; digit_sel = d; out_ready = r; reset = rs;
    @(posedge clk);
    model_step(s, d, r, rs);
    #1;
  endtask

  task automatic hold_digit(input int idx, input logic [6:0] s, input int n, input logic r);
    logic [3:0] sel;
    sel = 4'b0001 << idx;
    repeat (n) tick(s, sel, r, 1'b0);
  endtask

  task automatic do_reset();
    tick(7'h7F, 4'b0, 1'b0, 1'b1);
    tick(7'h7F, 4'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    tick(7'h00, 4'b0001, 1'b1, 1'b0);
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || bcd_out !== 16'h0 || digit_err !== 4'h0 || overrun !== 1'b0) begin
      errs++;
      $display("FAIL reset_values: got v=%b bcd=%h err=%b ovr=%b want 0/0000/0000/0",
               out_valid, bcd_out, digit_err, overrun);
    end
  endtask

  task automatic test_basic_frame();
    int vals [4] = '{3, 0, 2, 7};
    int rise_at = -1;
    int high = 0;
    logic [15:0] cap_bcd = 16'h0;
    logic [3:0]  cap_err = 4'hA;
    do_reset();
    for (int j = 0; j < 3; j++) hold_digit(j, glyph[vals[j]], 6, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k < 6) tick(glyph[vals[3]], 4'b1000, 1'b1, 1'b0);
      else tick(7'h7F, 4'b0, 1'b1, 1'b0);
      if (out_valid === 1'b1) begin
        high++;
        if (rise_at < 0) begin
          rise_at = k; cap_bcd = bcd_out; cap_err = digit_err;
        end
      end
    end
    checks++;
    if (rise_at != S + 2) begin
      errs++; $display("FAIL basic_latency: got %0d want %0d", rise_at, S + 2);
    end
    checks++;
    if (cap_bcd !== 16'h7203) begin
      errs++; $display("FAIL basic_bcd: got %h want 7203", cap_bcd);
    end
    checks++;
    if (cap_err !== 4'b0) begin
      errs++; $display("FAIL basic_err: got %b want 0000", cap_err);
    end
    checks++;
    if (high != 1) begin
      errs++; $display("FAIL basic_pulse: got %0d cycles want 1", high);
    end
  endtask

  task automatic test_short_run();
    int seen = 0;
    do_reset();
    hold_digit(1, glyph[1], S - 1, 1'b1);
    tick(7'h7F, 4'b0, 1'b1, 1'b0);
    hold_digit(0, glyph[8], 6, 1'b1);
    hold_digit(2, glyph[6], 6, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k < 6) tick(glyph[5], 4'b1000, 1'b1, 1'b0);
      else tick(7'h7F, 4'b0, 1'b1, 1'b0);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++; $display("FAIL short_run_capture: got %0d valid cycles want 0", seen);
    end
    hold_digit(1, glyph[1], 6, 1'b0);
    repeat (3) tick(7'h7F, 4'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || bcd_out !== 16'h5618) begin
      errs++; $display("FAIL short_run_frame: got v=%b bcd=%h want 1/5618", out_valid, bcd_out);
    end
  endtask

  task automatic test_blank();
    do_reset();
    hold_digit(0, glyph[4], 6, 1'b0);
    hold_digit(1, glyph[5], 6, 1'b0);
    hold_digit(2, 7'h7F, 6, 1'b0);
    hold_digit(3, glyph[9], 6, 1'b0);
    repeat (2) tick(7'h7F, 4'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || bcd_out !== 16'h9F54 || digit_err !== 4'b0100) begin
      errs++;
      $display("FAIL blank_digit: got v=%b bcd=%h err=%b want 1/9f54/0100",
               out_valid, bcd_out, digit_err);
    end
  endtask

  task automatic test_overrun();
    int moved = 0;
    do_reset();
    for (int j = 0; j < 4; j++) hold_digit(j, glyph[j + 1], 6, 1'b0);
    repeat (2) tick(7'h7F, 4'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || bcd_out !== 16'h4321 || overrun !== 1'b0) begin
      errs++;
      $display("FAIL overrun_first: got v=%b bcd=%h ovr=%b want 1/4321/0",
               out_valid, bcd_out, overrun);
    end
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 6; k++) begin
        tick(glyph[j + 5], 4'b0001 << j, 1'b0, 1'b0);
        if (out_valid !== 1'b1 || bcd_out !== 16'h4321) moved++;
      end
    end
    checks++;
    if (moved != 0) begin
      errs++; $display("FAIL overrun_hold: got %0d unstable cycles want 0", moved);
    end
    repeat (3) tick(7'h7F, 4'b0, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || bcd_out !== 16'h4321) begin
      errs++; $display("FAIL overrun_flag: got ovr=%b bcd=%h want 1/4321", overrun, bcd_out);
    end
    tick(7'h7F, 4'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL overrun_release: got v=%b want 0", out_valid);
    end
    repeat (4) tick(7'h7F, 4'b0, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b0) begin
      errs++; $display("FAIL overrun_sticky: got ovr=%b v=%b want 1/0", overrun, out_valid);
    end
  endtask

  task automatic test_onehot_and_reset();
    int seen = 0;
    do_reset();
    repeat (10) tick(glyph[3], 4'b0011, 1'b0, 1'b0);
    hold_digit(2, glyph[4], 6, 1'b0);
    hold_digit(3, glyph[9], 6, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick(7'h7F, 4'b0, 1'b0, 1'b0);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++; $display("FAIL multi_sel_capture: got %0d valid cycles want 0", seen);
    end
    hold_digit(0, glyph[1], 6, 1'b0);
    hold_digit(1, glyph[6], 6, 1'b0);
    repeat (3) tick(7'h7F, 4'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || bcd_out !== 16'h9461) begin
      errs++; $display("FAIL multi_sel_frame: got v=%b bcd=%h want 1/9461", out_valid, bcd_out);
    end
    for (int j = 0; j < 3; j++) hold_digit(j, glyph[7], 6, 1'b0);
    tick(7'h7F, 4'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || bcd_out !== 16'h0 || digit_err !== 4'h0 || overrun !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: got v=%b bcd=%h err=%b ovr=%b want 0/0000/0000/0",
               out_valid, bcd_out, digit_err, overrun);
    end
    seen = 0;
    hold_digit(3, glyph[2], 6, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick(7'h7F, 4'b0, 1'b0, 1'b0);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++; $display("FAIL post_reset_partial: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    for (int j = 0; j < 4; j++) hold_digit(j, glyph[j + 1], 6, 1'b0);
    repeat (2) tick(7'h7F, 4'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) hold_digit(j, glyph[j + 5], 6, 1'b0);
    for (int k = 0; k < 6; k++) tick(glyph[8], 4'b1000, (k == 5), 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL coincide_handshake: got v=%b want 0", out_valid);
    end
    tick(7'h7F, 4'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || bcd_out !== 16'h8765 || overrun !== 1'b0) begin
      errs++;
      $display("FAIL coincide_next: got v=%b bcd=%h ovr=%b want 1/8765/0",
               out_valid, bcd_out, overrun);
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [3:0] d;
    int n;
    int rdy_bias;
    do_reset();
    for (int blk = 0; blk < 150; blk++) begin
      if ($urandom_range(0, 9) < 8) s = glyph[$urandom_range(0, 9)];
      else if ($urandom_range(0, 1) == 0) s = 7'h7F;
      else s = 7'($urandom);
      if ($urandom_range(0, 9) < 8) d = 4'b0001 << $urandom_range(0, 3);
      else d = 4'($urandom);
      n = $urandom_range(1, 7);
      rdy_bias = (blk % 40 < 20) ? 3 : 1;
      for (int k = 0; k < n; k++) begin
        tick(s, d, ($urandom_range(0, 3) < rdy_bias), ($urandom_range(0, 299) == 0));
        checks++;
        if (out_valid !== m_valid || bcd_out !== m_bcd || digit_err !== m_derr ||
            overrun !== m_ovr) begin
          errs++;
          $display("FAIL random_model: got v=%b bcd=%h err=%b ovr=%b want %b/%h/%b/%b",
                   out_valid, bcd_out, digit_err, overrun, m_valid, m_bcd, m_derr, m_ovr);
        end
      end
    end
  endtask

  initial begin
    segments = 7'h7F; digit_sel = 4'b0; out_ready = 1'b0; reset = 1'b1;
    model_step(7'h7F, 4'b0, 1'b0, 1'b1);
    test_reset();
    test_basic_frame();
    test_short_run();
    test_blank();
    test_overrun();
    test_onehot_and_reset();
    test_coincide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required to capture a digit.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port segments  input  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}, per the team seven-segment encoding.
REQ-005 SHALL have port digit_sel  input  4  active-high one-hot digit strobe; bit i selects digit i (0 = least significant).
REQ-006 SHALL have port out_ready  input  1  consumer accepts frame.
REQ-007 SHALL have port out_valid  output  1  frame available.
REQ-008 SHALL have port bcd_out  output  16  digit i in bits [4i+3:4i].
REQ-009 SHALL have port digit_err  output  4  bit i set if digit i pattern was not a decimal glyph.
REQ-010 SHALL have port overrun  output  1  sticky: a completed frame was discarded.

Function
REQ-011 SHALL register segments and digit_sel once (sample stage) before any decision logic.
REQ-012 SHALL keep a run counter: 1 on a sample differing from the previous sample, +1 on an identical sample, saturating at STABLE_CYCLES.
REQ-013 SHALL hold the run counter at 0 while the sampled digit_sel is not one-hot (zero or multiple bits); such samples never capture.
REQ-014 SHALL capture exactly once per stable run, on the cycle the run counter reaches STABLE_CYCLES; saturation causes no re-capture.
REQ-015 SHALL decode on capture: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
REQ-016 SHALL store any other pattern, blank 1111111 included, as 4'hF with the digit's error bit set; a valid decode clears that bit.
REQ-017 SHALL write captures into a shadow buffer (4 nibbles, 4 error bits, 4-bit captured mask); recapturing a digit overwrites its nibble.
REQ-018 SHALL use FSM states COLLECT and PRESENT.
REQ-019 COLLECT: when the mask becomes 4'b1111, SHALL copy shadow to bcd_out/digit_err, clear mask, set out_valid, enter PRESENT, all on the next edge.
REQ-020 PRESENT: SHALL hold out_valid, bcd_out and digit_err stable until out_valid && out_ready is sampled.
REQ-021 SHALL on handshake deassert out_valid next edge and return to COLLECT; shadow contents and mask are retained.
REQ-022 PRESENT: captures SHALL continue into the shadow; if the mask completes before the handshake, SHALL set overrun, clear the mask and discard that frame.
REQ-023 SHALL give handshake priority when a mask completion coincides with the handshake: return to COLLECT, set no overrun, keep the completed mask so the frame presents on the following edge.
REQ-024 SHALL present a frame with out_valid rising exactly STABLE_CYCLES+2 edges after the first edge sampling the final digit's pair.
REQ-025 SHALL keep overrun sticky until reset.
REQ-026 SHALL ignore out_ready while out_valid is low.

Reset
REQ-027 SHALL on reset set out_valid=0, bcd_out=16'h0000, digit_err=4'h0, overrun=0, mask=0, run counter=0, sample registers=0, state=COLLECT.
REQ-028 SHALL let reset asserted mid-frame or in PRESENT abandon all partial and pending data with no output pulse.
REQ-029 SHALL begin capturing on the first edge after reset deasserts.

Verification
REQ-030 Digits 3,0,2,7 (sel 0001..1000), each held 6 cycles, STABLE_CYCLES=4, out_ready=1 -> bcd_out=16'h7203, digit_err=0, out_valid high 1 cycle.
REQ-031 Digit 1 pattern held 3 cycles then changed, STABLE_CYCLES=4 -> no capture, mask bit 1 stays 0.
REQ-032 Digit 2 driven with 1111111 -> nibble 2 = 4'hF, digit_err=4'b0100, frame still presented.
REQ-033 out_ready=0, two full scans -> first frame held unchanged, overrun=1 after second scan completes; then out_ready=1 -> out_valid falls next edge.
REQ-034 digit_sel=4'b0011 held 10 cycles -> no capture; reset pulsed with 3 of 4 digits captured -> outputs at reset values, next frame needs all 4 digits.
REQ-035 Mask completion on same edge as handshake -> no overrun, new frame out_valid on the following edge.
